// File: rtl/ptr_sync_multi.sv
// ptr_sync_multi
//   Multi-channel pointer synchroniser for the pointer crossings of async
//   FIFO / AXIS data-FIFO cores. Each channel samples its asynchronous
//   pointer through NUM_STG back-to-back flops. It can optionally require the
//   sampled value to stay stable for FILTER_CYC extra cycles before it is
//   accepted. In Gray mode it converts the accepted value to binary and
//   flags any accepted change of more than one bit.
//
//   A value first sampled on edge k appears on ptr_out NUM_STG+FILTER_CYC
//   edges later. It is still flagged by ptr_upd for one cycle.
//
// Ports
//   clk         single clock for all state
//   rst         synchronous, active-high reset (clears every flop)
//   ptr_in      NUM_CH async pointers, channel c at [c*PTR_W +: PTR_W]
//   err_clr     clears err_sticky on all channels (a new err wins)
//   ptr_out     registered synchronised pointer (binary when GRAY_IN=1)
//   ptr_upd     one-cycle pulse per channel when ptr_out changed
//   err         one-cycle pulse per channel on an illegal multi-bit Gray jump
//   err_sticky  latched err, held until err_clr
module ptr_sync_multi #(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_STG    = 2,
  parameter int NUM_CH     = 1,
  parameter int GRAY_IN    = 1,
  parameter int FILTER_CYC = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]     ptr_in,
  input  logic                                         err_clr,
  output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]     ptr_out,
  output logic [NUM_CH-1:0]                            ptr_upd,
  output logic [NUM_CH-1:0]                            err,
  output logic [NUM_CH-1:0]                            err_sticky
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    // Pure flop-to-flop chain so the placer can pack it tightly.
    (* ASYNC_REG = "TRUE" *) logic [PTR_W-1:0] stg_reg [NUM_STG];

    logic [PTR_W-1:0] s;
    logic [PTR_W-1:0] held_reg;
    logic [PTR_W-1:0] out_reg;
    logic [PTR_W-1:0] diff;
    logic             accept;
    logic             change;
    logic             jump;
    logic             upd_reg;
    logic             err_reg;
    logic             sticky_reg;

    assign s = stg_reg[NUM_STG-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < NUM_STG; i++) begin
          stg_reg[i] <= '0;
        end
      end else begin
        stg_reg[0] <= ptr_in[gi*PTR_W +: PTR_W];
        for (int i = 1; i < NUM_STG; i++) begin
          stg_reg[i] <= stg_reg[i-1];
        end
      end
    end

    if (FILTER_CYC > 0) begin : g_filt
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYC - 1);

      logic [PTR_W-1:0] prev_reg;
      logic [CNT_W-1:0] cnt_reg;

      // cnt counts consecutive equal samples and saturates at F-1. Accept once
      // the last F+1 samples agree.
      always_ff @(posedge clk) begin
        if (rst) begin
          prev_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          prev_reg <= s;
          if (s != prev_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign accept = (s == prev_reg) && (cnt_reg == CNT_MAX);
    end else begin : g_nofilt
      assign accept = 1'b1;
    end

    assign change = accept && (s != held_reg);
    assign diff   = s ^ held_reg;
    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign jump   = (GRAY_IN != 0) && (|(diff & (diff - PTR_W'(1))));

    always_ff @(posedge clk) begin
      if (rst) begin
        held_reg   <= '0;
        out_reg    <= '0;
        upd_reg    <= 1'b0;
        err_reg    <= 1'b0;
        sticky_reg <= 1'b0;
      end else begin
        upd_reg <= 1'b0;
        err_reg <= 1'b0;
        if (change) begin
          held_reg <= s;
          out_reg  <= (GRAY_IN != 0) ? gray2bin(s) : s;
          upd_reg  <= 1'b1;
          err_reg  <= jump;
        end
        if (change && jump) begin
          sticky_reg <= 1'b1;
        end else if (err_clr) begin
          sticky_reg <= 1'b0;
        end
      end
    end

    assign ptr_out[gi*PTR_W +: PTR_W] = out_reg;
    assign ptr_upd[gi]                = upd_reg;
    assign err[gi]                    = err_reg;
    assign err_sticky[gi]             = sticky_reg;
  end

endmodule
